// File: rtl/cpu_dbg_pkg.sv
// Purpose: shared command, FSM-state and halt-cause encodings for the CPU run/step controller.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package cpu_dbg_pkg;

    // Command opcodes carried on cmd_op.
    typedef enum logic [1:0] {
        OP_HALT = 2'b00,
        OP_RUN  = 2'b01,
        OP_STEP = 2'b10,
        OP_CLR  = 2'b11
    } cmd_op_t;

    // Controller FSM states.
    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10
    } run_state_t;

    // Reason for the most recent entry into HALT.
    typedef enum logic [1:0] {
        HC_NONE = 2'b00,
        HC_CMD  = 2'b01,
        HC_STEP = 2'b10,
        HC_BP   = 2'b11
    } halt_cause_t;

endpackage

// File: rtl/cpu_bp_match.sv
// Purpose: NUM_BP-way PC breakpoint comparator; hit when any enabled entry equals pc.
// Latency: purely combinational.
// Backpressure: none.
// Ports: pc (current core PC), bp_addr (entry i at [i*PC_W +: PC_W]), bp_en (per-entry enable), hit.
module cpu_bp_match #(
    parameter int NUM_BP = 2,
    parameter int PC_W   = 32
) (
    input  logic [PC_W-1:0]        pc,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]      bp_en,
    output logic                   hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_en[i] && (pc == bp_addr[i*PC_W +: PC_W])) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Purpose: run/step/breakpoint controller gating the multicycle core's clock enable; counts cycles and instructions.
// Latency: cpu_en combinational from cpu_state/cpu_pc/halt_req; FSM, cause and counters update on the next CLK edge.
// Backpressure: cmd_ready is low while a STEP is in progress; commands transfer on cmd_valid && cmd_ready.
// Ports: CLK/RST (async active-low); cmd_valid/cmd_ready/cmd_op/cmd_arg command channel; halt_req (synchronised);
//        cpu_state/cpu_pc core observation; bp_addr/bp_en breakpoints; cpu_en, halted, halt_cause, cycle_cnt, instr_cnt.
// Build option: define CPU_RUN_CTRL_BP_EN to instantiate the breakpoint comparators; otherwise bp_addr/bp_en are ignored.
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int                 PC_W        = 32,
    parameter int                 STATE_W     = 3,
    parameter logic [STATE_W-1:0] FETCH_STATE = '0,
    parameter int                 CNT_W       = 32,
    parameter int                 STEP_W      = 16,
    parameter int                 NUM_BP      = 2,
    parameter bit                 RUN_ON_RST  = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [STEP_W-1:0]      cmd_arg,
    input  logic                   halt_req,
    input  logic [STATE_W-1:0]     cpu_state,
    input  logic [PC_W-1:0]        cpu_pc,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]      bp_en,
    output logic                   cpu_en,
    output logic                   halted,
    output logic [1:0]             halt_cause,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       instr_cnt
);

    localparam run_state_t RST_STATE = RUN_ON_RST ? S_RUN : S_HALT;

    run_state_t        state, state_nxt;
    logic [STEP_W-1:0] step_rem;
    logic              skip;
    logic              halt_pend;
    logic              bp_hit;

    logic boundary, active;
    logic cmd_acc, run_acc, step_any_acc, step_acc, step0_acc, clr_acc, halt_acc;
    logic stop_hreq, stop_step, stop_bp, stop;

`ifdef CPU_RUN_CTRL_BP_EN
    cpu_bp_match #(
        .NUM_BP (NUM_BP),
        .PC_W   (PC_W)
    ) u_bp_match (
        .pc      (cpu_pc),
        .bp_addr (bp_addr),
        .bp_en   (bp_en),
        .hit     (bp_hit)
    );
`else
    logic unused_bp;
    assign unused_bp = ^{cpu_pc, bp_addr, bp_en};
    assign bp_hit    = 1'b0;
`endif

    assign boundary     = (cpu_state == FETCH_STATE);
    assign active       = (state != S_HALT);

    assign cmd_acc      = cmd_valid && cmd_ready;
    assign run_acc      = cmd_acc && (cmd_op == OP_RUN);
    assign step_any_acc = cmd_acc && (cmd_op == OP_STEP);
    assign step_acc     = step_any_acc && (cmd_arg != '0);
    assign step0_acc    = step_any_acc && (cmd_arg == '0);
    assign clr_acc      = cmd_acc && (cmd_op == OP_CLR);
    // A HALT command only means something while free-running; it is folded into the halt_req path
    // so the core still stops cleanly at the next fetch.
    assign halt_acc     = cmd_acc && (cmd_op == OP_HALT) && (state == S_RUN);

    // Stops are only taken at a fetch boundary so the core is always parked in fetch.
    assign stop_hreq = active && boundary && (halt_req || halt_pend);
    assign stop_step = active && boundary && (state == S_STEP) && (step_rem == '0);
    assign stop_bp   = active && boundary && bp_hit && !skip;
    assign stop      = stop_hreq || stop_step || stop_bp;

    // FSM state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: an accepted RUN/STEP overrides a stop taken in the same cycle.
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = S_HALT;
        end
        if (run_acc) begin
            state_nxt = S_RUN;
        end else if (step_acc) begin
            state_nxt = S_STEP;
        end
    end

    // FSM outputs
    always_comb begin
        cpu_en    = active && !stop;
        halted    = (state == S_HALT);
        cmd_ready = (state != S_STEP);
    end

    // Datapath: cause, pending halt, skip flag, step budget, counters.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            halt_cause <= HC_NONE;
            halt_pend  <= 1'b0;
            skip       <= 1'b1;
            step_rem   <= '0;
            cycle_cnt  <= '0;
            instr_cnt  <= '0;
        end else begin
            if (stop_hreq) begin
                halt_cause <= HC_CMD;
            end else if (stop_step) begin
                halt_cause <= HC_STEP;
            end else if (stop_bp) begin
                halt_cause <= HC_BP;
            end else if (step0_acc) begin
                halt_cause <= HC_STEP;
            end

            // Any HALT entry drops a pending request; a request seen in HALT is only kept when a
            // RUN/STEP is accepted alongside it, so the resumed core stops at its first fetch.
            if (stop) begin
                halt_pend <= 1'b0;
            end else if (halt_acc || (halt_req && (active || run_acc || step_acc))) begin
                halt_pend <= 1'b1;
            end

            // Skip lets a resume from a breakpoint execute the instruction it stopped on.
            if (run_acc || step_any_acc) begin
                skip <= 1'b1;
            end else if (boundary && cpu_en) begin
                skip <= 1'b0;
            end

            if (step_acc) begin
                step_rem <= cmd_arg;
            end else if ((state == S_STEP) && boundary && cpu_en) begin
                step_rem <= step_rem - STEP_W'(1);
            end

            if (clr_acc) begin
                cycle_cnt <= '0;
                instr_cnt <= '0;
            end else begin
                if (cpu_en) begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                end
                if (cpu_en && boundary) begin
                    instr_cnt <= instr_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Purpose: directed bench for cpu_run_ctrl driving a 4-state fetch/execute core model.
// Latency: checks sampled on the falling edge, stimulus applied 1ns after the rising edge.
// Backpressure: commands are only issued while cmd_ready is expected high.
module tb_cpu_run_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        halt_req;
    logic [2:0]  cpu_state;
    logic [31:0] cpu_pc;
    logic [63:0] bp_addr;
    logic [1:0]  bp_en;
    logic        cpu_en;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    cpu_run_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .halt_req   (halt_req),
        .cpu_state  (cpu_state),
        .cpu_pc     (cpu_pc),
        .bp_addr    (bp_addr),
        .bp_en      (bp_en),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .halt_cause (halt_cause),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );

    // Core model: fetch(0) -> 1 -> 2 -> 3 -> fetch, PC advances by 4 at the end of state 3.
    logic [2:0]  core_s;
    logic [31:0] core_pc;
    logic        pc_load;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            core_s  <= 3'd0;
            core_pc <= 32'd0;
        end else if (pc_load) begin
            core_pc <= 32'd0;
        end else if (cpu_en) begin
            core_s <= (core_s == 3'd3) ? 3'd0 : core_s + 3'd1;
            if (core_s == 3'd3) begin
                core_pc <= core_pc + 32'd4;
            end
        end
    end

    assign cpu_state = core_s;
    assign cpu_pc    = core_pc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [15:0] arg);
        @(posedge CLK);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_halt(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge CLK);
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit rbad;
        bit enbad;
        bit found;
        int nb;

        RST       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_arg   = 16'd0;
        halt_req  = 1'b0;
        bp_addr   = 64'd0;
        bp_en     = 2'b00;
        pc_load   = 1'b0;

        // Reset state
        @(negedge CLK);
        chk("rst_halted", halted, 0);
        chk("rst_cause", halt_cause, 0);
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_instr", instr_cnt, 0);
        chk("rst_cpu_en", cpu_en, 1);
        chk("rst_ready", cmd_ready, 1);
        @(posedge CLK);
        #1 RST = 1'b1;

        // Free run for 20 cycles
        repeat (20) @(posedge CLK);
        @(negedge CLK);
        chk("run_cycle", cycle_cnt, 20);
        chk("run_instr", instr_cnt, 5);

        // HALT command, stops at the next fetch
        send_cmd(2'b00, 16'd0);
        wait_halt(20, ok);
        chk("hcmd_halted", ok, 1);
        chk("hcmd_cause", halt_cause, 1);
        chk("hcmd_cycle", cycle_cnt, 24);
        chk("hcmd_instr", instr_cnt, 6);
        chk("hcmd_state", cpu_state, 0);

        // STEP 3
        send_cmd(2'b10, 16'd3);
        nb   = 0;
        rbad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (halted) break;
            if (cpu_en && cpu_state == 3'd0) nb++;
            if (cmd_ready) rbad = 1'b1;
        end
        chk("step_halted", halted, 1);
        chk("step_bounds", nb, 3);
        chk("step_ready_lo", rbad, 0);
        chk("step_cause", halt_cause, 2);
        chk("step_state", cpu_state, 0);
        chk("step_instr", instr_cnt, 9);
        chk("step_cycle", cycle_cnt, 36);
        chk("step_pc", cpu_pc, 32'h24);

        // Breakpoint at 0x10, run from PC 0
        pc_load = 1'b1;
        @(posedge CLK);
        #1 pc_load = 1'b0;
        bp_addr = {32'h0, 32'h0000_0010};
        bp_en   = 2'b01;
        send_cmd(2'b01, 16'd0);
        wait_halt(40, ok);
`ifdef CPU_RUN_CTRL_BP_EN
        chk("bp_halted", ok, 1);
        chk("bp_cause", halt_cause, 3);
        chk("bp_pc", cpu_pc, 32'h10);
        chk("bp_state", cpu_state, 0);
        chk("bp_instr", instr_cnt, 13);
        chk("bp_cycle", cycle_cnt, 52);
`else
        chk("nobp_running", ok, 0);
`endif
        // Resume: the instruction at the breakpoint executes, no re-hit
        send_cmd(2'b01, 16'd0);
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        chk("resume_running", halted, 0);
`ifdef CPU_RUN_CTRL_BP_EN
        chk("resume_pc", cpu_pc, 32'h18);
`endif
        bp_en = 2'b00;

        // halt_req pulse mid-instruction
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (cpu_state == 3'd2) begin
                found = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        chk("hreq_found_s2", found, 1);
        halt_req = 1'b1;
        @(posedge CLK);
        #1 halt_req = 1'b0;
        @(negedge CLK);
        chk("hreq_en_mid", cpu_en, 1);
        @(negedge CLK);
        chk("hreq_en_bnd", cpu_en, 0);
        chk("hreq_bnd_state", cpu_state, 0);
        @(negedge CLK);
        chk("hreq_halted", halted, 1);
        chk("hreq_cause", halt_cause, 1);

        // CLR on a counting boundary: clear wins
        @(posedge CLK);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        @(posedge CLK);
        #1 cmd_op = 2'b11;
        @(negedge CLK);
        chk("clr_bnd_en", cpu_en, 1);
        chk("clr_bnd_state", cpu_state, 0);
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        @(negedge CLK);
        chk("clr_cycle", cycle_cnt, 0);
        chk("clr_instr", instr_cnt, 0);
        send_cmd(2'b00, 16'd0);
        wait_halt(20, ok);
        chk("clr_halt", ok, 1);
        chk("clr_cycle_after", cycle_cnt, 3);
        chk("clr_instr_after", instr_cnt, 0);

        // STEP with arg 0 is a no-op that reports step-done
        send_cmd(2'b10, 16'd0);
        enbad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (cpu_en) enbad = 1'b1;
        end
        chk("step0_no_en", enbad, 0);
        chk("step0_halted", halted, 1);
        chk("step0_cause", halt_cause, 2);
        chk("step0_cycle", cycle_cnt, 3);

        // halt_req together with RUN while halted: zero instructions run
        @(posedge CLK);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        halt_req  = 1'b1;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        halt_req  = 1'b0;
        @(negedge CLK);
        chk("simul_running", halted, 0);
        chk("simul_en", cpu_en, 0);
        @(negedge CLK);
        chk("simul_halted", halted, 1);
        chk("simul_cause", halt_cause, 1);
        chk("simul_instr", instr_cnt, 0);
        chk("simul_cycle", cycle_cnt, 3);

        // Reset during STEP 5
        send_cmd(2'b10, 16'd5);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst2_halted", halted, 0);
        chk("rst2_cause", halt_cause, 0);
        chk("rst2_cycle", cycle_cnt, 0);
        chk("rst2_instr", instr_cnt, 0);
        chk("rst2_ready", cmd_ready, 1);
        @(posedge CLK);
        #1 RST = 1'b1;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("rst2_run_cycle", cycle_cnt, 4);
        chk("rst2_run_instr", instr_cnt, 1);
        chk("rst2_run_ready", cmd_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/step controller for the multicycle CPU.
- Gates the CPU's clock enable so the core can free-run, execute exactly N instructions, or stop at a PC breakpoint.
- Counts executed cycles and instructions.
- Sits between the board/bench control logic and the core; watches the core's state and PC.

Parameters:
PC_W, 32, width of cpu_pc and breakpoint addresses
STATE_W, 3, width of cpu_state
FETCH_STATE, 3'b000, cpu_state encoding of the instruction-fetch state
CNT_W, 32, width of cycle and instruction counters
STEP_W, 16, width of step-count argument
NUM_BP, 2, number of breakpoint comparators
RUN_ON_RST, 1, 1: enter RUN after reset; 0: enter HALT

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
cmd_valid  in  1  command strobe
cmd_ready  out  1  command accept; transfer when valid&&ready
cmd_op  in  2  00 HALT, 01 RUN, 10 STEP, 11 CLR (clear counters)
cmd_arg  in  STEP_W  instruction count for STEP
halt_req  in  1  asynchronous-source halt request, already synchronised
cpu_state  in  STATE_W  core FSM state
cpu_pc  in  PC_W  core currentPC
bp_addr  in  NUM_BP*PC_W  breakpoint addresses, entry i at [i*PC_W +: PC_W]
bp_en  in  NUM_BP  per-breakpoint enable
cpu_en  out  1  clock enable to core (combinational)
halted  out  1  controller in HALT
halt_cause  out  2  00 none/reset, 01 command/halt_req, 10 step done, 11 breakpoint
cycle_cnt  out  CNT_W  cycles with cpu_en=1
instr_cnt  out  CNT_W  fetch cycles with cpu_en=1

Behaviour:
- Clock and reset: single clock CLK; RST asynchronous, active-low.
- Reset values:
  - FSM = RUN if RUN_ON_RST, else HALT.
  - halt_cause = 00; counters = 0; step remaining = 0; skip flag = 1.
- FSM states: HALT, RUN, STEP.
- Boundary: a cycle with cpu_state==FETCH_STATE.
- cpu_en:
  - 1 in RUN/STEP unless a stop condition holds this cycle.
  - Always 0 in HALT.
  - Stop conditions are evaluated only at a boundary, so the core always halts sitting in fetch.
- Stop conditions, in priority order:
  1. halt_req → HALT, cause 01.
  2. STEP with remaining==0 → HALT, cause 10.
  3. Breakpoint: bp_en[i] && cpu_pc==bp_addr[i] && !skip → HALT, cause 11.
- halt_req outside a boundary: stays pending (latched) until the next boundary; the latch clears on that HALT.
- Skip flag:
  - Set on every accepted RUN/STEP.
  - Cleared after the first boundary with cpu_en=1.
  - Resuming from a breakpoint therefore executes that instruction.
- Step count: remaining decrements on each boundary with cpu_en=1. STEP N executes exactly N instructions.
- Command acceptance: cmd_ready = (FSM != STEP). Accepted commands take effect next cycle:
  - HALT op: if FSM is RUN, treated as halt_req (latched); in HALT, no-op.
  - RUN: FSM→RUN.
  - STEP with arg≥1: remaining←arg, FSM→STEP.
  - STEP with arg=0: no-op, cause←10.
  - CLR: both counters →0; FSM unchanged. A CLR increment in the same cycle is lost (clear wins).
- Simultaneous halt_req and accepted RUN/STEP in HALT: command applied; pending halt stops the core at the first boundary (zero instructions executed).
- Counters:
  - cycle_cnt += 1 per cycle with cpu_en.
  - instr_cnt += 1 per boundary with cpu_en.
  - Both wrap modulo 2^CNT_W.
- halted = (FSM==HALT). halt_cause holds until the next HALT entry; it is not cleared on RUN.
- Latency: cpu_en responds combinationally to cpu_state/cpu_pc in the same cycle; FSM and cause update on the next edge.

Optional Feature:
CPU_RUN_CTRL_BP_EN:
- Defined: breakpoint comparators instantiated as specified.
- Undefined: bp_addr/bp_en ports remain but are ignored; cause 11 never produced; no comparator logic.

Decomposition:
- Package cpu_dbg_pkg holds:
  - cmd_op codes: OP_HALT, OP_RUN, OP_STEP, OP_CLR.
  - FSM encodings: S_HALT, S_RUN, S_STEP.
  - halt_cause codes: HC_NONE, HC_CMD, HC_STEP, HC_BP.
- One sub-module, cpu_bp_match: a parametrised NUM_BP-way comparator producing a hit bit. Compiled out with the macro.

Test Plan:
- RUN_ON_RST=1, RST released, 4-cycle fetch-execute model → cpu_en=1 immediately; after 20 cycles cycle_cnt=20, instr_cnt=5.
- HALT then STEP arg=3 → exactly 3 boundaries with cpu_en=1; halted=1, halt_cause=10, cpu_state=FETCH_STATE, instr_cnt advanced by 3; cmd_ready=0 throughout STEP.
- bp_addr[0]=0x0000_0010, bp_en=01, RUN from PC 0 → halt at boundary with cpu_pc=0x10, cause 11, instruction at 0x10 not counted. RUN again → 0x10 executes, no re-hit.
- halt_req pulse mid-instruction (non-fetch state) → cpu_en stays 1 until the next boundary, then 0; cause 01.
- CLR in the same cycle as a counting boundary → both counters read 0 next cycle; STEP arg=0 → stays HALT, cause 10, no cpu_en.
- Assert RST low during STEP with remaining=5 → immediate FSM reset state, counters 0, cause 00, remaining 0.
